seeker2: RTL and testbench

- Sync-header alignment seeker for the 64b/66b Aurora RX recovery path.
- Each data-valid event, it examines the 194-bit gearbox buffer and checks every candidate 66-bit block alignment for a valid 2-bit sync header ("01" or "10").
- It holds the current alignment while that alignment's header stays valid. On a miss it jumps to the lowest valid candidate.
- The result, block_offset, drives the downstream block extractor.

---
 rtl/seeker2.sv | 91 +++++++++
 tb/tb_seeker2.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seeker2.sv
// seeker2: 64b/66b sync-header alignment seeker.
// Checks every candidate block alignment in the gearbox buffer for a valid
// "01"/"10" header. It holds the current offset while that offset's header
// stays valid, and re-seeks to the lowest valid candidate after MISS_LIMIT
// consecutive misses.
module seeker2 #(
    parameter int N_OFFSETS  = 128,
    parameter int MISS_LIMIT = 1,
    parameter int BUF_W      = 194,
    parameter int OFF_W      = $clog2(N_OFFSETS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             buffer_dv,
    input  logic             gbox_dv,
    input  logic [BUF_W-1:0] gbox_buffer,
    input  logic [5:0]       gbox_cnt,
    output logic [OFF_W-1:0] block_offset
);

    localparam logic [4:0] LIMIT5 = 5'(MISS_LIMIT);
    localparam logic [3:0] LIMIT4 = 4'(MISS_LIMIT);

    logic [N_OFFSETS-1:0] valid;
    logic [OFF_W-1:0]     first_idx;
    logic                 any_valid;
    logic                 evt;
    logic [4:0]           miss_inc;

    logic [OFF_W-1:0]     off_q, off_d;
    logic [3:0]           miss_q, miss_d;

    // gbox_cnt and the payload-only bits never influence the search.
    logic unused_inputs;
    assign unused_inputs = ^gbox_cnt ^ ^gbox_buffer;

    assign evt      = buffer_dv && gbox_dv;
    assign miss_inc = {1'b0, miss_q} + 5'd1;

    // Header of candidate k sits at the two oldest bits of its window.
    for (genvar k = 0; k < N_OFFSETS; k++) begin : g_hdr
        assign valid[k] = gbox_buffer[BUF_W-1-k] ^ gbox_buffer[BUF_W-2-k];
    end

    // Priority encoder: lowest valid index wins (scan high to low, last hit sticks).
    always_comb begin
        first_idx = '0;
        any_valid = 1'b0;
        for (int k = N_OFFSETS - 1; k >= 0; k--) begin
            if (valid[k]) begin
                first_idx = OFF_W'(k);
                any_valid = 1'b1;
            end
        end
    end

    // Next-state: hold on a hit, count misses, re-seek when the limit is reached.
    always_comb begin
        off_d  = off_q;
        miss_d = miss_q;
        if (evt) begin
            if (valid[off_q]) begin
                miss_d = '0;
            end else if (miss_inc >= LIMIT5) begin
                if (any_valid) begin
                    off_d  = first_idx;
                    miss_d = '0;
                end else begin
                    // Nothing to lock onto: keep offset, stay saturated.
                    miss_d = LIMIT4;
                end
            end else begin
                miss_d = miss_inc[3:0];
            end
        end
    end

    // State registers; reset overrides any evaluation in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            off_q  <= '0;
            miss_q <= '0;
        end else begin
            off_q  <= off_d;
            miss_q <= miss_d;
        end
    end

    assign block_offset = off_q;

endmodule

// File: tb/tb_seeker2.sv
// Scoreboard bench for seeker2: two instances (MISS_LIMIT 1 and 3) share
// stimulus; a reference model pushes the expected offsets per driven cycle,
// and they are popped and compared one cycle later.
module tb_seeker2;

    logic         clk = 1'b0;
    logic         rst;
    logic         bdv, gdv;
    logic [193:0] buff;
    logic [5:0]   cnt;
    logic [6:0]   off1, off3;

    always #5 clk = ~clk;

    seeker2 #(.MISS_LIMIT(1)) u_l1 (
        .clk_i(clk), .rst_i(rst), .buffer_dv(bdv), .gbox_dv(gdv),
        .gbox_buffer(buff), .gbox_cnt(cnt), .block_offset(off1)
    );

    seeker2 #(.MISS_LIMIT(3)) u_l3 (
        .clk_i(clk), .rst_i(rst), .buffer_dv(bdv), .gbox_dv(gdv),
        .gbox_buffer(buff), .gbox_cnt(cnt), .block_offset(off3)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0] o1;
        logic [6:0] o3;
    } exp_t;
    exp_t q[$];

    int m_off  [2];
    int m_miss [2];
    int m_lim  [2] = '{1, 3};

    task automatic chk(input string tag, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int lowest_valid(input logic [193:0] b);
        for (int k = 0; k < 128; k++)
            if (b[193-k] != b[192-k]) return k;
        return -1;
    endfunction

    task automatic model_step(input int i, input logic [193:0] b);
        int lv;
        lv = lowest_valid(b);
        if (b[193-m_off[i]] != b[192-m_off[i]]) begin
            m_miss[i] = 0;
        end else if (m_miss[i] + 1 >= m_lim[i]) begin
            if (lv >= 0) begin
                m_off[i]  = lv;
                m_miss[i] = 0;
            end else begin
                m_miss[i] = m_lim[i];
            end
        end else begin
            m_miss[i] = m_miss[i] + 1;
        end
    endtask

    // One clock: drive inputs, push model expectation, pop and compare after the edge.
    task automatic cyc(input logic r, input logic bd, input logic gd, input logic [193:0] b);
        logic [193:0] bb;
        exp_t e;
        bb = b;
        bb[64:0] = {$urandom, $urandom, $urandom};  // payload-only bits: must not matter
        rst  = r;
        bdv  = bd;
        gdv  = gd;
        buff = bb;
        cnt  = 6'($urandom);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_off[i]  = 0;
                m_miss[i] = 0;
            end else if (bd && gd) begin
                model_step(i, bb);
            end
        end
        e.o1 = 7'(m_off[0]);
        e.o3 = 7'(m_off[1]);
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("off_lim1", off1, e.o1);
        chk("off_lim3", off3, e.o3);
    endtask

    // dv pulse followed by 7 idle cycles; idle cycles toggle one dv alone.
    task automatic pulse(input logic [193:0] b);
        cyc(1'b0, 1'b1, 1'b1, b);
        for (int j = 0; j < 7; j++)
            cyc(1'b0, j[0], ~j[0], b);
    endtask

    function automatic logic [193:0] onebit(input int p);
        logic [193:0] b;
        b = '0;
        b[p] = 1'b1;
        return b;
    endfunction

    initial begin
        logic [193:0] b;
        rst = 1'b1; bdv = 1'b0; gdv = 1'b0; buff = '0; cnt = '0;
        m_off  = '{0, 0};
        m_miss = '{0, 0};

        // Reset with a header-ish bit present and no dv
        b = onebit(129);
        cyc(1'b1, 1'b0, 1'b0, b);
        cyc(1'b1, 1'b0, 1'b0, b);
        chk("reset_l1", off1, 7'd0);
        chk("reset_l3", off3, 7'd0);
        for (int j = 0; j < 4; j++) cyc(1'b0, 1'b0, 1'b0, b);
        chk("idle_after_reset", off1, 7'd0);

        // Single bit at 127: valid {65,66}
        b = onebit(127);
        cyc(1'b0, 1'b1, 1'b1, b);
        chk("first_jump", off1, 7'd65);
        for (int j = 0; j < 7; j++) cyc(1'b0, 1'b0, 1'b0, b);
        for (int p = 1; p < 32; p++) pulse(b);
        chk("hold65", off1, 7'd65);

        // Sweep the single set bit upward
        for (int i = 128; i <= 193; i++) begin
            b = onebit(i);
            for (int p = 0; p < 32; p++) pulse(b);
            if (i == 128) chk("hyst128", off1, 7'd65);
            if (i == 129) chk("jump129", off1, 7'd63);
        end
        chk("sweep_end", off1, 7'd0);

        // Lock to 37, then all-zero buffer must hold it
        b = onebit(155);
        pulse(b);
        chk("lock37", off1, 7'd37);
        for (int p = 0; p < 6; p++) pulse('0);
        chk("zero_hold37", off1, 7'd37);

        // MISS_LIMIT=3 behaviour on the second instance
        cyc(1'b1, 1'b0, 1'b0, '0);
        pulse(onebit(192));                 // offset 0 valid
        b = onebit(150);                    // valid {42,43}
        pulse(b);
        pulse(b);
        chk("lim3_hold2", off3, 7'd0);
        pulse(b);
        chk("lim3_jump3", off3, 7'd42);
        pulse(onebit(100));                 // valid {92,93}: miss 1
        pulse(onebit(100));                 // miss 2
        pulse(b);                           // 42 valid again: clears
        pulse(onebit(100));
        pulse(onebit(100));
        chk("lim3_cleared", off3, 7'd42);
        pulse(onebit(100));
        chk("lim3_jump92", off3, 7'd92);

        // Back-to-back events
        cyc(1'b0, 1'b1, 1'b1, onebit(180));
        cyc(1'b0, 1'b1, 1'b1, onebit(170));
        chk("b2b_l1", off1, 7'd22);

        // Reset coinciding with a dv event
        cyc(1'b1, 1'b1, 1'b1, onebit(150));
        chk("rst_wins_l1", off1, 7'd0);
        chk("rst_wins_l3", off3, 7'd0);
        cyc(1'b0, 1'b1, 1'b1, onebit(192));
        chk("post_rst_l3", off3, 7'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
